cbr: RTL

CBR -- requirements
Module: cbr

---
 rtl/cbr_pkg.sv | 39 +++
 rtl/cbr_control_store.sv | 44 ++++
 rtl/cbr.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cbr_pkg.sv
// Shared control-unit definitions: sequencing field codes, control bit indices,
// the default microword and the microroutine entry addresses.
package cbr_pkg;

  // Sequencing field, microword bits [1:0]
  localparam logic [1:0] SEQ_HOLD     = 2'b00;
  localparam logic [1:0] SEQ_DISPATCH = 2'b01;
  localparam logic [1:0] SEQ_INC      = 2'b10;
  localparam logic [1:0] SEQ_RET      = 2'b11;

  // C23 is the HALT control
  localparam int unsigned C23_BIT = 23;

  // Unprogrammed locations return to fetch with every datapath control off
  localparam logic [31:0] CW_RETURN = 32'h0000_0003;

  // Microroutine entry points
  localparam logic [6:0] UR_ENTRY_07 = 7'h07;
  localparam logic [6:0] UR_ENTRY_09 = 7'h09;
  localparam logic [6:0] UR_ENTRY_0B = 7'h0B;
  localparam logic [6:0] UR_ENTRY_0D = 7'h0D;
  localparam logic [6:0] UR_ENTRY_0F = 7'h0F;
  localparam logic [6:0] UR_ENTRY_11 = 7'h11;
  localparam logic [6:0] UR_ENTRY_13 = 7'h13;
  localparam logic [6:0] UR_ENTRY_15 = 7'h15;
  localparam logic [6:0] UR_ENTRY_17 = 7'h17;
  localparam logic [6:0] UR_ENTRY_19 = 7'h19;
  localparam logic [6:0] UR_ENTRY_1B = 7'h1B;
  localparam logic [6:0] UR_ENTRY_1D = 7'h1D;
  localparam logic [6:0] UR_ENTRY_23 = 7'h23;

  typedef enum logic {StIdle, StPending} step_state_e;

  // True when a sequencing field parks the CAR at the end of an instruction
  function automatic logic is_seq_ret(input logic [1:0] seq);
    return seq == SEQ_RET;
  endfunction

endpackage

// File: rtl/cbr_control_store.sv
// 128-entry microprogram ROM with combinational read.
module cbr_control_store
  import cbr_pkg::*;
#(
  parameter int unsigned CW_WIDTH = 32
) (
  input  logic [6:0]          addr_i,
  output logic [CW_WIDTH-1:0] word_o
);

  logic [31:0] word;

  // Table lookup; anything not listed reads as a return-to-fetch microword
  always_comb begin
    word = CW_RETURN;
    unique case (addr_i)
      7'h00:       word = 32'h0000_0102;  // fetch
      7'h01:       word = 32'h0000_0202;
      7'h02:       word = 32'h0000_0401;  // decode / dispatch
      UR_ENTRY_07: word = 32'h0000_0802;
      7'h08:       word = 32'h0000_1003;
      UR_ENTRY_09: word = 32'h0000_2003;
      UR_ENTRY_0B: word = 32'h0000_4002;
      7'h0C:       word = 32'h0000_8003;
      UR_ENTRY_0D: word = 32'h0001_0003;
      UR_ENTRY_0F: word = 32'h0002_0002;
      7'h10:       word = 32'h0004_0003;
      UR_ENTRY_11: word = 32'h0008_0003;
      UR_ENTRY_13: word = 32'h0080_0003;  // HALT (C23) then return
      UR_ENTRY_15: word = 32'h0010_0003;
      UR_ENTRY_17: word = 32'h0020_0002;
      7'h18:       word = 32'h0040_0003;
      UR_ENTRY_19: word = 32'h0100_0003;
      UR_ENTRY_1B: word = 32'h0200_0003;
      UR_ENTRY_1D: word = 32'h0400_0002;
      7'h1E:       word = 32'h0800_0003;
      UR_ENTRY_23: word = 32'h1000_0000;  // hold
      default:     word = CW_RETURN;
    endcase
  end

  assign word_o = CW_WIDTH'(word);

endmodule

// File: rtl/cbr.sv
// Control-unit block: control store, step-button conditioning, single-step FSM,
// halt latch and executed-microinstruction counter.
// Build option: define CBR_DEBOUNCE_EN to debounce the synchronized step button.
module cbr
  import cbr_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CW_WIDTH        = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [6:0]          i_car_data,
  input  logic                i_step_mode,
  input  logic                i_step_btn,
  output logic [CW_WIDTH-1:0] o_control_word,
  output logic [1:0]          o_control_word_car,
  output logic                o_ctrl_halt,
  output logic                o_next_instr_stimulus,
  output logic                o_fetch_wait,
  output logic [15:0]         o_uinstr_count
);

  if (CW_WIDTH < 24) begin : g_bad_cw_width
    $error("CW_WIDTH must hold control bit C23");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic [CW_WIDTH-1:0] cw;
  logic                halt_q, halt_d;
  logic [1:0]          sync_q, sync_d;
  logic                step_lvl;
  logic                prev_q, prev_d;
  logic                step_rise;
  step_state_e         state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;

  cbr_control_store #(
    .CW_WIDTH(CW_WIDTH)
  ) u_store (
    .addr_i(i_car_data),
    .word_o(cw)
  );

  assign o_control_word     = cw;
  assign o_control_word_car = cw[1:0];
  // Combine with the live bit so HALT shows in the cycle its word is addressed
  assign o_ctrl_halt        = cw[C23_BIT] | halt_q;
  assign o_fetch_wait       = i_step_mode & is_seq_ret(cw[1:0]) & ~o_ctrl_halt;

  // Two-flop synchronizer input shift
  always_comb begin
    sync_d = {sync_q[0], i_step_btn};
  end

`ifdef CBR_DEBOUNCE_EN
  localparam int unsigned DebCntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic               level_q, level_d;
  logic [DebCntW-1:0] deb_cnt_q, deb_cnt_d;

  // Accept a new level only after it has held for DEBOUNCE_CYCLES samples
  always_comb begin
    level_d   = level_q;
    deb_cnt_d = deb_cnt_q;
    if (sync_q[1] == level_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DebCntW'(DEBOUNCE_CYCLES - 1)) begin
      level_d   = sync_q[1];
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  // Debounce state
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      level_q   <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      level_q   <= level_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign step_lvl = level_q;
`else
  assign step_lvl = sync_q[1];
`endif

  // Rising-edge detect on the conditioned button level
  always_comb begin
    prev_d    = step_lvl;
    step_rise = step_lvl & ~prev_q;
  end

  // Step FSM next state: at most one step queued, cancelled by halt or leaving step mode
  always_comb begin
    state_d = state_q;
    if (!i_step_mode || o_ctrl_halt) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    if (step_rise) state_d = StPending;
        StPending: if (o_fetch_wait) state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  // Step FSM output: the pulse is issued from the registered PENDING state only
  always_comb begin
    o_next_instr_stimulus = (state_q == StPending) & o_fetch_wait;
  end

  // Halt latch and saturating microinstruction counter
  always_comb begin
    halt_d = halt_q | cw[C23_BIT];
    cnt_d  = cnt_q;
    if (!o_ctrl_halt && !o_fetch_wait && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // State registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      halt_q  <= 1'b0;
      sync_q  <= 2'b00;
      prev_q  <= 1'b0;
      state_q <= StIdle;
      cnt_q   <= 16'h0000;
    end else begin
      halt_q  <= halt_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_uinstr_count = cnt_q;

endmodule
